cordic_rotation_iter: RTL and testbench
=======================================

// Module: cordic_rotation_iter
// PURPOSE
//  Iterative CORDIC rotation-mode engine: rotates vector (x_in,y_in) by angle theta_in, one micro-rotation per clock.
//  Sits directly downstream of the vectoring stage and consumes its Q5.11 angle to apply Givens rotations to companion rows.
//  Valid/ready on input and output; one transaction in flight.
// PARAMETERS
//  WIDTH   16  data/angle width; x, y, theta signed Q5.11 (1.0 = 2048)
//  N_ITER  12  micro-rotations per transaction, 1..12; atan table has 12 entries
//  GUARD   2   extra MSBs on internal x/y datapath (absorbs CORDIC gain 1.647)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input transaction offered
//  in_ready   out  1      engine idle, can accept
//  x_in       in   WIDTH  signed Q5.11 x
//  y_in       in   WIDTH  signed Q5.11 y
//  theta_in   in   WIDTH  signed Q5.11 angle, legal range [-6434,+6434] (+-pi)
//  out_valid  out  1      result available
//  out_ready  in   1      downstream accepts result
//  x_out      out  WIDTH  rotated x, saturated to WIDTH
//  y_out      out  WIDTH  rotated y, saturated to WIDTH
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, x_out=y_out=0, iteration counter=0, internal x/y/z=0.
//  FSM: IDLE -(in_valid&in_ready)-> ITER -(cnt==N_ITER-1)-> [COMP if CORDIC_GAIN_COMP_EN] -> DONE -(out_ready)-> IDLE.
//  in_ready=1 only in IDLE; out_valid=1 only in DONE. No same-cycle pass-through: in_ready rises the cycle after the out handshake.
//  Accept edge: sign-extend x,y to WIDTH+GUARD; pre-rotate:
//   theta>3217 (pi/2): x=-x, y=-y, z=theta-6434; theta<-3217: x=-x, y=-y, z=theta+6434; else z=theta.
//  ITER, iteration i (i=0..N_ITER-1, one per edge): z>=0: x-=y>>>i, y+=x>>>i, z-=ATAN[i];
//   z<0: x+=y>>>i, y-=x>>>i, z+=ATAN[i]. Shifts arithmetic, both updates use pre-edge x/y.
//  Latency: out_valid high N_ITER edges after accept edge (N_ITER+1 with gain comp). Throughput 1 per N_ITER+2 cycles min.
//  Output: x/y saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and registered on entry to DONE; held stable while out_valid&!out_ready.
//  theta outside +-6434: no error flag; result is that of theta wrapped by pre-rotation only (undefined accuracy).
//  in_valid while busy: ignored (in_ready=0); inputs need not be held after accept.
//  rst_n low mid-operation: immediate return to reset state; in-flight transaction discarded, no out_valid.
// CONFIGURATION
//  CORDIC_GAIN_COMP_EN defined: extra COMP state, one edge, multiplies x,y by 1/K via shift-add
//   (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9) (=0.6074) before saturation; output magnitude = input magnitude.
//  Not defined: no COMP state; outputs carry CORDIC gain K=1.6468 (downstream compensates).
// STRUCTURE
//  Shared package cordic_pkg: ATAN table (1608,949,501,254,127,63,31,15,7,3,1,0), FIX_PI=6434,
//   FIX_HALF_PI=3217, state encoding, 1/K shift constants; reused by the vectoring stage.
//  One sub-module: cordic_gain_comp (combinational shift-add 1/K scaler, instantiated only under the macro).
// TESTING
//  1. Reset: rst_n=0 -> in_ready=1, out_valid=0, x_out=y_out=0 asynchronously, before any clock edge.
//  2. x=1024,y=0,theta=0 -> comp on: x_out=1024+-4, y_out=0+-4; comp off: x_out=1686+-6, y_out=0+-6.
//  3. x=1024,y=0,theta=3217 -> comp on: x_out=0+-4, y_out=1024+-4; theta=6434 -> x_out=-1024+-4, y_out=0+-4.
//  4. Pre-rotation negative side: x=1024,y=0,theta=-4826 (-3pi/4) -> comp on: x_out=-724+-4, y_out=-724+-4.
//  5. Saturation, comp off: x=y=16000, theta=1608 (pi/4) -> x_out~0+-40, y_out=32767.
//  6. Backpressure/reset: out_ready=0 for 5 cycles -> out_valid, x_out, y_out stable, in_ready=0;
//     rst_n pulsed low at iteration 6 -> no out_valid, next transaction correct with latency N_ITER(+1).

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q5.11 angle table, pi constants, FSM encoding and 1/K shift amounts.
// Used by the rotation engine (CORDIC_GAIN_COMP_EN selects the gain-compensation stage) and the vectoring stage.
package cordic_pkg;

  localparam int FIX_PI      = 6434;
  localparam int FIX_HALF_PI = 3217;

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 = 0.6074
  localparam int INVK_SH0 = 1;
  localparam int INVK_SH1 = 3;
  localparam int INVK_SH2 = 6;
  localparam int INVK_SH3 = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_e;

  // atan(2^-i) in Q5.11
  function automatic int atan_lut(input int idx);
    case (idx)
      0:       return 1608;
      1:       return 949;
      2:       return 501;
      3:       return 254;
      4:       return 127;
      5:       return 63;
      6:       return 31;
      7:       return 15;
      8:       return 7;
      9:       return 3;
      10:      return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Combinational 1/K scaler: removes the CORDIC gain with a four-term shift-add.
// Only instantiated when CORDIC_GAIN_COMP_EN is defined.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0] i_v,
  output logic signed [W-1:0] o_v
);

  assign o_v = (i_v >>> INVK_SH0) + (i_v >>> INVK_SH1)
             - (i_v >>> INVK_SH2) - (i_v >>> INVK_SH3);

endmodule

// File: rtl/cordic_rotation_iter.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock, one transaction in flight.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales the result by 1/K before saturation.
module cordic_rotation_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N_ITER = 12,
  parameter int GUARD  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] theta_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out
);

  localparam int IW = WIDTH + GUARD;
  localparam int ZW = WIDTH + 2;
  localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CW-1:0]        LAST      = CW'(N_ITER - 1);
  localparam logic signed [ZW-1:0] Z_PI      = ZW'(FIX_PI);
  localparam logic signed [ZW-1:0] Z_HALF_PI = ZW'(FIX_HALF_PI);
  localparam logic signed [IW-1:0] SAT_MAX   = IW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN   = -IW'(2 ** (WIDTH - 1));

  cordic_state_e          r_state, w_state_next;
  logic [CW-1:0]          r_cnt;
  logic signed [IW-1:0]   r_x, r_y;
  logic signed [ZW-1:0]   r_z;
  logic signed [WIDTH-1:0] r_x_out, r_y_out;

  logic signed [IW-1:0]   w_x_ext, w_y_ext, w_x_pre, w_y_pre;
  logic signed [ZW-1:0]   w_th_ext, w_z_pre;
  logic signed [IW-1:0]   w_x_sh, w_y_sh, w_x_rot, w_y_rot;
  logic signed [ZW-1:0]   w_atan, w_z_rot;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_MAX)
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SAT_MIN)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return v[WIDTH-1:0];
  endfunction

  assign w_x_ext  = IW'(x_in);
  assign w_y_ext  = IW'(y_in);
  assign w_th_ext = ZW'(theta_in);

  // Fold angles beyond +-pi/2 into convergence range by a 180-degree pre-rotation
  always_comb begin
    w_x_pre = w_x_ext;
    w_y_pre = w_y_ext;
    w_z_pre = w_th_ext;
    if (w_th_ext > Z_HALF_PI) begin
      w_x_pre = -w_x_ext;
      w_y_pre = -w_y_ext;
      w_z_pre = w_th_ext - Z_PI;
    end else if (w_th_ext < -Z_HALF_PI) begin
      w_x_pre = -w_x_ext;
      w_y_pre = -w_y_ext;
      w_z_pre = w_th_ext + Z_PI;
    end
  end

  assign w_x_sh = r_x >>> r_cnt;
  assign w_y_sh = r_y >>> r_cnt;
  assign w_atan = ZW'(atan_lut(int'(r_cnt)));

  always_comb begin
    w_x_rot = r_x + w_y_sh;
    w_y_rot = r_y - w_x_sh;
    w_z_rot = r_z + w_atan;
    if (!r_z[ZW-1]) begin
      w_x_rot = r_x - w_y_sh;
      w_y_rot = r_y + w_x_sh;
      w_z_rot = r_z - w_atan;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [IW-1:0] w_x_comp, w_y_comp;

  cordic_gain_comp #(.W(IW)) u_comp_x (.i_v(r_x), .o_v(w_x_comp));
  cordic_gain_comp #(.W(IW)) u_comp_y (.i_v(r_y), .o_v(w_y_comp));
`endif

  always_comb begin
    w_state_next = r_state;
    in_ready     = (r_state == ST_IDLE);
    out_valid    = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: if (in_valid) w_state_next = ST_ITER;
`ifdef CORDIC_GAIN_COMP_EN
      ST_ITER: if (r_cnt == LAST) w_state_next = ST_COMP;
`else
      ST_ITER: if (r_cnt == LAST) w_state_next = ST_DONE;
`endif
      ST_COMP: w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x   <= w_x_pre;
            r_y   <= w_y_pre;
            r_z   <= w_z_pre;
            r_cnt <= '0;
          end
        end
        ST_ITER: begin
          r_x   <= w_x_rot;
          r_y   <= w_y_rot;
          r_z   <= w_z_rot;
          r_cnt <= r_cnt + CW'(1);
`ifndef CORDIC_GAIN_COMP_EN
          if (r_cnt == LAST) begin
            r_x_out <= sat(w_x_rot);
            r_y_out <= sat(w_y_rot);
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: begin
          r_x_out <= sat(w_x_comp);
          r_y_out <= sat(w_y_comp);
        end
`endif
        default: ;
      endcase
    end
  end

  assign x_out = r_x_out;
  assign y_out = r_y_out;

endmodule

// File: tb/tb_cordic_rotation_iter.sv
// Scoreboard bench for cordic_rotation_iter: directed vectors, expected results queued at accept,
// monitor pops and checks value and latency on each output. Honours CORDIC_GAIN_COMP_EN.
module tb_cordic_rotation_iter;

  localparam int WIDTH  = 16;
  localparam int N_ITER = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = N_ITER + 1;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = N_ITER;
  localparam bit COMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [WIDTH-1:0] x_in = '0, y_in = '0, theta_in = '0;
  logic in_ready, out_valid;
  logic signed [WIDTH-1:0] x_out, y_out;

  cordic_rotation_iter #(.WIDTH(WIDTH), .N_ITER(N_ITER), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    ex, ey, tx, ty, acc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int expv, input int tol);
    total++;
    if (act < expv - tol || act > expv + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (+-%0d)", nm, act, expv, tol);
    end
  endtask

  // Monitor: one comparison set per out_valid episode
  initial begin : monitor
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!out_valid) seen = 1'b0;
      else if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got out_valid=1 x=%0d y=%0d want no output", x_out, y_out);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_x"}, int'(x_out), e.ex, e.tx);
          chk({e.name, "_y"}, int'(y_out), e.ey, e.ty);
          chk({e.name, "_lat"}, cyc - e.acc, LAT, 0);
          $display("tx %s: x=%0d y=%0d lat=%0d", e.name, x_out, y_out, cyc - e.acc);
        end
      end
    end
  end

  task automatic send(input string nm, input int x, input int y, input int th,
                      input int ex, input int ey, input int tx, input int ty, input bit expect_out);
    exp_t e;
    int   k;
    @(negedge clk);
    x_in = 16'(x); y_in = 16'(y); theta_in = 16'(th);
    in_valid = 1'b1;
    for (k = 0; k < 100 && !in_ready; k++) @(negedge clk);
    if (!in_ready) chk({nm, "_accept_timeout"}, int'(in_ready), 1, 0);
    @(posedge clk);
    #1;
    if (expect_out) begin
      e = '{nm, ex, ey, tx, ty, cyc};
      sb.push_back(e);
    end
    in_valid = 1'b0;
    x_in = '0; y_in = '0; theta_in = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_pending", sb.size(), 0, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int cx, cy, k;
    // asynchronous reset values, before the first clock edge
    #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    chk("rst_y_out", int'(y_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send("rot0",     1024, 0,  0,     COMP ? 1024 : 1686,  0,                   COMP ? 4 : 6, COMP ? 4 : 6, 1'b1);
    send("rot90",    1024, 0,  3217,  0,                   COMP ? 1024 : 1686,  COMP ? 4 : 6, COMP ? 4 : 6, 1'b1);
    send("rot180",   1024, 0,  6434,  COMP ? -1024 : -1686, 0,                  COMP ? 4 : 6, COMP ? 4 : 6, 1'b1);
    send("rotm135",  1024, 0, -4826,  COMP ? -724 : -1192, COMP ? -724 : -1192, COMP ? 4 : 6, COMP ? 4 : 6, 1'b1);
    send("rotm45",   0, 1024, -1608,  COMP ? 724 : 1192,   COMP ? 724 : 1192,   COMP ? 4 : 6, COMP ? 4 : 6, 1'b1);
    // in_valid while busy must be ignored
    repeat (3) begin
      @(negedge clk);
      x_in = 16'sd5000; y_in = -16'sd5000; theta_in = 16'sd100; in_valid = 1'b1;
      chk("busy_in_ready", int'(in_ready), 0, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    send("rotmix",  -2048, 512, 1000, COMP ? -2049 : -3374, COMP ? -509 : -838, COMP ? 8 : 10, COMP ? 8 : 10, 1'b1);
    drain();

    // saturation with backpressure
    out_ready = 1'b0;
    send("sat45", 16000, 16000, 1608, 0, COMP ? 22627 : 32767, 40, COMP ? 40 : 0, 1'b1);
    for (k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    chk("bp_out_valid_seen", int'(out_valid), 1, 0);
    cx = int'(x_out);
    cy = int'(y_out);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1, 0);
      chk("bp_x_hold", int'(x_out), cx, 0);
      chk("bp_y_hold", int'(y_out), cy, 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_in_ready", int'(in_ready), 1, 0);
    chk("hs_out_valid", int'(out_valid), 0, 0);
    drain();

    // reset in the middle of an iteration run
    send("aborted", 1024, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_output", int'(out_valid), 0, 0);
    send("post_rst", 1024, 0, 3217, 0, COMP ? 1024 : 1686, COMP ? 4 : 6, COMP ? 4 : 6, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
